// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier.
// The divider uses the same state encodings, so values must not change.
//   mult_state_e : IDLE / RUN / DONE encodings
//   cnt_w(n)     : width of an iteration counter that can hold n
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_abs.sv
// Combinational conditional two's-complement negate.
// Used as |x| on the operands (neg = sign bit) and as -x on the result.
//   neg : negate when 1, pass through when 0
//   val : W-bit input
//   res : W-bit result; -(-2^(W-1)) wraps to 2^(W-1), which is the
//         correct magnitude when res is read as unsigned
module mult_abs #(
    parameter int W = 4
) (
    input  logic         neg,
    input  logic [W-1:0] val,
    output logic [W-1:0] res
);

    assign res = neg ? ((~val) + W'(1)) : val;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Operands are converted to magnitudes on accept, multiplied unsigned,
// and the sign is reapplied to the 2N-bit result on the edge entering DONE.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE and the
// product stays stable until out_ready is seen high.
//
// Ports:
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   in_valid     : operand pair valid
//   in_ready     : operands can be accepted (IDLE only)
//   multiplicand : operand A, N bits
//   multiplier   : operand B, N bits
//   out_valid    : product valid, held until accepted
//   out_ready    : consumer accepts product
//   product      : A*B, 2N bits
//   busy         : high in RUN or DONE
//   dbg_state    : current FSM state
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N      = 4,
    parameter int SIGNED = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             busy,
    output mult_state_e      dbg_state
);

    localparam int CNT_W     = cnt_w(N);
    localparam bit IS_SIGNED = (SIGNED != 0);

    mult_state_e       state_q, state_d;
    logic [N-1:0]      m_q, m_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      q_q, q_d;
    logic              carry_q, carry_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [2*N-1:0]    product_q, product_d;

    logic [N-1:0]      mcand_mag;
    logic [N-1:0]      mplier_mag;
    logic [2*N-1:0]    prod_signed;
    logic [N:0]        sum;

    mult_abs #(.W(N)) u_abs_a (
        .neg (IS_SIGNED && multiplicand[N-1]),
        .val (multiplicand),
        .res (mcand_mag)
    );

    mult_abs #(.W(N)) u_abs_b (
        .neg (IS_SIGNED && multiplier[N-1]),
        .val (multiplier),
        .res (mplier_mag)
    );

    mult_abs #(.W(2*N)) u_neg_p (
        .neg (neg_q),
        .val ({a_q, q_q}),
        .res (prod_signed)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        count_d   = count_q;
        product_d = product_q;

        // {carry,A} after the conditional add; the shift below consumes it
        sum = q_q[0] ? ({1'b0, a_q} + {1'b0, m_q}) : {carry_q, a_q};

        case (state_q)
            MULT_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = MULT_RUN;
                    m_d     = mcand_mag;
                    q_d     = mplier_mag;
                    a_d     = '0;
                    carry_d = 1'b0;
                    count_d = CNT_W'(N);
                    neg_d   = IS_SIGNED & (multiplicand[N-1] ^ multiplier[N-1]);
                end
            end
            MULT_RUN: begin
                if (count_q == '0) begin
                    state_d   = MULT_DONE;
                    product_d = prod_signed;
                end else begin
                    // {carry,A,Q} >>= 1: carry falls into A's MSB, A's LSB into Q
                    carry_d = 1'b0;
                    a_d     = sum[N:1];
                    q_d     = {sum[0], q_q[N-1:1]};
                    count_d = count_q - CNT_W'(1);
                end
            end
            MULT_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = MULT_IDLE;
                end
            end
            default: state_d = MULT_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state register.
        in_ready_d  = (state_d == MULT_IDLE);
        out_valid_d = (state_d == MULT_DONE);
        busy_d      = (state_d != MULT_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MULT_IDLE;
            m_q         <= '0;
            a_q         <= '0;
            q_q         <= '0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            a_q         <= a_d;
            q_q         <= q_d;
            carry_q     <= carry_d;
            neg_q       <= neg_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            product_q   <= product_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: one unsigned and one signed instance (N=4),
// sharing clock and reset. Inputs change #1 after a rising edge or on the
// falling edge; outputs are sampled on the falling edge or #1 after a rise.
module tb_shift_add_multiplier;
    import shift_add_multiplier_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [3:0]  mcand      [2];
    logic [3:0]  mplier     [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [7:0]  product    [2];
    logic        busy       [2];
    mult_state_e dbg_state  [2];

    logic [7:0]  exp_q[$];
    int          checks;
    int          errors;

    shift_add_multiplier #(.N(4), .SIGNED(0)) u_dut_u (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid[0]),
        .in_ready     (in_ready[0]),
        .multiplicand (mcand[0]),
        .multiplier   (mplier[0]),
        .out_valid    (out_valid[0]),
        .out_ready    (out_ready[0]),
        .product      (product[0]),
        .busy         (busy[0]),
        .dbg_state    (dbg_state[0])
    );

    shift_add_multiplier #(.N(4), .SIGNED(1)) u_dut_s (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid[1]),
        .in_ready     (in_ready[1]),
        .multiplicand (mcand[1]),
        .multiplier   (mplier[1]),
        .out_valid    (out_valid[1]),
        .out_ready    (out_ready[1]),
        .product      (product[1]),
        .busy         (busy[1]),
        .dbg_state    (dbg_state[1])
    );

    // clock / watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference product, 8-bit two's complement for the signed instance.
    function automatic logic [7:0] model(input int m, input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic signed [7:0] p;
        if (m == 1) begin
            sa = $signed({{4{a[3]}}, a});
            sb = $signed({{4{b[3]}}, b});
            p  = sa * sb;
            return p;
        end
        return {4'b0, a} * {4'b0, b};
    endfunction

    // Drive one operand pair on instance m and collect its product.
    // hold: cycles to keep out_ready low once DONE is reached.
    // junk: keep in_valid high with changing operands while busy.
    task automatic run_op(input int m, input logic [3:0] a, input logic [3:0] b,
                          input int hold, input bit junk, input logic [7:0] exp);
        int         n;
        int         lat;
        logic [7:0] got;
        logic [7:0] want;
        n = 0;
        while (in_ready[m] !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("in_ready_idle", in_ready[m], 1);
        out_ready[m] = (hold == 0);
        mcand[m]     = a;
        mplier[m]    = b;
        in_valid[m]  = 1'b1;
        @(posedge clock);
        exp_q.push_back(exp);
        #1;
        in_valid[m] = junk;
        lat = 0;
        while (lat < 20) begin
            @(posedge clock);
            lat++;
            #1;
            if (out_valid[m] === 1'b1) break;
            chk("in_ready_run", in_ready[m], 0);
            chk("busy_run", busy[m], 1);
            if (junk) begin
                mcand[m]  = 4'($urandom_range(0, 15));
                mplier[m] = 4'($urandom_range(0, 15));
            end
        end
        chk("latency", lat, 5);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", out_valid[m], 1);
            chk("hold_product", product[m], exp_q.size() > 0 ? exp_q[0] : 8'h00);
            chk("hold_in_ready", in_ready[m], 0);
        end
        @(negedge clock);
        out_ready[m] = 1'b1;
        got = product[m];
        chk("valid_at_hs", out_valid[m], 1);
        @(posedge clock);
        #1;
        want = exp_q.pop_front();
        chk("product", got, want);
        chk("valid_after_hs", out_valid[m], 0);
        chk("in_ready_after_hs", in_ready[m], 1);
        chk("busy_after_hs", busy[m], 0);
        in_valid[m]  = 1'b0;
        out_ready[m] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        for (int m = 0; m < 2; m++) begin
            in_valid[m]  = 1'b0;
            mcand[m]     = '0;
            mplier[m]    = '0;
            out_ready[m] = 1'b0;
        end

        // reset state
        @(negedge clock);
        @(negedge clock);
        for (int m = 0; m < 2; m++) begin
            chk("rst_in_ready", in_ready[m], 0);
            chk("rst_out_valid", out_valid[m], 0);
            chk("rst_busy", busy[m], 0);
            chk("rst_product", product[m], 0);
            chk("rst_state", dbg_state[m], MULT_IDLE);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("in_ready_after_rst_u", in_ready[0], 1);
        chk("in_ready_after_rst_s", in_ready[1], 1);

        // directed unsigned
        run_op(0, 4'd13, 4'd11, 0, 1'b0, 8'h8F);
        run_op(0, 4'd15, 4'd15, 6, 1'b0, 8'hE1);
        run_op(0, 4'd0,  4'd9,  0, 1'b0, 8'h00);

        // directed signed
        run_op(1, 4'h8, 4'h8, 0, 1'b0, 8'h40);
        run_op(1, 4'hD, 4'h5, 0, 1'b0, 8'hF1);
        run_op(1, 4'h7, 4'h8, 2, 1'b0, 8'hC8);

        // operands offered during RUN are ignored; next pair goes after delivery
        run_op(0, 4'd6, 4'd7, 1, 1'b1, 8'd42);
        run_op(0, 4'd5, 4'd9, 0, 1'b0, 8'd45);

        // asynchronous reset two edges into RUN
        @(negedge clock);
        out_ready[0] = 1'b1;
        mcand[0]     = 4'd13;
        mplier[0]    = 4'd11;
        in_valid[0]  = 1'b1;
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        chk("pre_rst_busy", busy[0], 1);
        reset = 1'b0;
        #1;
        chk("async_out_valid", out_valid[0], 0);
        chk("async_product", product[0], 0);
        chk("async_busy", busy[0], 0);
        chk("async_in_ready", in_ready[0], 0);
        chk("async_state", dbg_state[0], MULT_IDLE);
        @(negedge clock);
        reset        = 1'b1;
        out_ready[0] = 1'b0;
        run_op(0, 4'd3, 4'd3, 0, 1'b0, 8'h09);

        // random, both modes
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [3:0] a;
                logic [3:0] b;
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                run_op(m, a, b, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), model(m, a, b));
            end
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
